fibonacci_multi_lane: RTL and testbench

- Parametrised Fibonacci sequence generator that emits LANES consecutive terms per output beat.
- Seeds and run length are loaded at start; output uses a valid/ready handshake, with sticky overflow detection and done/busy status.
- Generalises the single-rate and double-rate generators. Serves as a stimulus source for datapath benches in the sequential-basics set.

---
 rtl/fibonacci_multi_lane_if.sv | 24 ++
 rtl/fibonacci_multi_lane.sv | 186 ++++++++++++++++++
 tb/tb_fibonacci_multi_lane.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fibonacci_multi_lane_if.sv
// ---------------------------------------------------------------------------
// fibonacci_multi_lane_if
//   Output stream bundle of the multi-lane Fibonacci generator.
//
//   Signals:
//     out_valid  producer -> consumer  num holds a valid beat
//     out_ready  consumer -> producer  beat accepted when high with out_valid
//     num        producer -> consumer  LANES terms, lane i at bits i*WIDTH +: WIDTH
//
//   Modports:
//     master  the generator side (drives out_valid/num)
//     slave   the consumer side (drives out_ready)
// ---------------------------------------------------------------------------
interface fibonacci_multi_lane_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 2
);
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*WIDTH-1:0]   num;

    modport master (output out_valid, output num, input  out_ready);
    modport slave  (input  out_valid, input  num, output out_ready);
endinterface

// File: rtl/fibonacci_multi_lane.sv
// ---------------------------------------------------------------------------
// fibonacci_multi_lane
//   Fibonacci sequence generator emitting LANES consecutive terms per beat.
//   Seeds and beat count are captured on an accepted start; beats leave through
//   a valid/ready stream at up to one beat per cycle.
//
//   Ports:
//     clk       clock, rising edge
//     rst       synchronous active-high reset
//     start     begin a run (ignored while busy)
//     seed0     term F0, captured on accepted start
//     seed1     term F1, captured on accepted start
//     len       number of beats to produce, captured on accepted start
//     m_out     output stream (out_valid / out_ready / num), master side
//     busy      high while a run is in progress
//     done      high after a run completes, until the next accepted start
//     overflow  sticky: a term of the current run exceeded 2^WIDTH-1
//
//   Build option:
//     FIB_SATURATE_EN  when defined, overflowing sums clamp to 2^WIDTH-1
//                      (also in the recurrence); otherwise terms wrap.
// ---------------------------------------------------------------------------
module fibonacci_multi_lane #(
    parameter int WIDTH = 16,
    parameter int LANES = 2,
    parameter int LEN_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WIDTH-1:0]             seed0,
    input  logic [WIDTH-1:0]             seed1,
    input  logic [LEN_W-1:0]             len,
    fibonacci_multi_lane_if.master       m_out,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One computed beat plus the two trailing terms that seed the next beat.
    typedef struct packed {
        logic                   ovf;
        logic [WIDTH-1:0]       p2;
        logic [WIDTH-1:0]       p1;
        logic [LANES*WIDTH-1:0] num;
    } beat_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_s0;
    logic [WIDTH-1:0]       r_s1;
    logic [WIDTH-1:0]       r_p2;
    logic [WIDTH-1:0]       r_p1;
    logic [LANES*WIDTH-1:0] r_num;
    logic [LEN_W-1:0]       r_left;     // beats still to present after the current one
    logic                   r_first;    // current beat is beat 0
    logic                   r_ovf;

    logic                   w_accept;
    logic                   w_xfer;
    logic                   w_last;
    beat_t                  w_beat;

    // Chains LANES terms from the two preceding terms a, b. n0 is the term
    // index of lane 0 (only 0, 1 or "2 or more" matters): indices 0 and 1 are
    // the seeds and are never sums, so they never flag overflow.
    function automatic beat_t f_next_beat(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] s0,
        input logic [WIDTH-1:0] s1,
        input int               n0
    );
        beat_t            res;
        logic [WIDTH-1:0] t2;
        logic [WIDTH-1:0] t1;
        logic [WIDTH-1:0] lane;
        logic [WIDTH:0]   sum;
        res = '0;
        t2  = a;
        t1  = b;
        for (int i = 0; i < LANES; i++) begin
            sum = {1'b0, t2} + {1'b0, t1};
            if (n0 + i == 0) begin
                lane = s0;
            end else if (n0 + i == 1) begin
                lane = s1;
            end else begin
                res.ovf = res.ovf | sum[WIDTH];
`ifdef FIB_SATURATE_EN
                lane = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
                lane = sum[WIDTH-1:0];
`endif
            end
            res.num[i*WIDTH +: WIDTH] = lane;
            t2 = t1;
            t1 = lane;
        end
        res.p2 = t2;
        res.p1 = t1;
        return res;
    endfunction

    assign w_accept = start && (r_state != RUN);
    assign w_xfer   = (r_state == RUN) && m_out.out_ready;
    assign w_last   = w_xfer && (r_left == '0);

    // Beat 0 is built straight from the ports so it can be presented one
    // cycle after start; later beats chain from the stored trailing terms.
    // With LANES=1 the beat after beat 0 is the second seed.
    always_comb begin
        if (w_accept) begin
            w_beat = f_next_beat('0, '0, seed0, seed1, 0);
        end else begin
            w_beat = f_next_beat(r_p2, r_p1, r_s0, r_s1,
                                 (LANES == 1 && r_first) ? 1 : 2);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: default first, so no path through this block leaves the output
        // unassigned and infers a latch.
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (w_accept) w_state_nxt = (len == '0) ? DONE : RUN;
            RUN:        if (w_last)   w_state_nxt = DONE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0    <= '0;
            r_s1    <= '0;
            r_p2    <= '0;
            r_p1    <= '0;
            r_num   <= '0;
            r_left  <= '0;
            r_first <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_s0    <= seed0;
            r_s1    <= seed1;
            r_first <= 1'b1;
            if (len == '0) begin
                r_left <= '0;
                r_ovf  <= 1'b0;
            end else begin
                r_left <= len - LEN_W'(1);
                r_ovf  <= w_beat.ovf;
                r_num  <= w_beat.num;
                r_p2   <= w_beat.p2;
                r_p1   <= w_beat.p1;
            end
        end else if (w_xfer && !w_last) begin
            // Stalled beats are untouched: everything here moves only on a transfer.
            r_left  <= r_left - LEN_W'(1);
            r_first <= 1'b0;
            r_ovf   <= r_ovf | w_beat.ovf;
            r_num   <= w_beat.num;
            r_p2    <= w_beat.p2;
            r_p1    <= w_beat.p1;
        end
    end

    assign m_out.out_valid = (r_state == RUN);
    assign m_out.num       = r_num;
    assign busy            = (r_state == RUN);
    assign done            = (r_state == DONE);
    assign overflow        = r_ovf;

endmodule

// File: tb/tb_fibonacci_multi_lane.sv
// ---------------------------------------------------------------------------
// tb_fibonacci_multi_lane
//   Directed bench for fibonacci_multi_lane: a LANES=2 instance and a LANES=1
//   instance, both WIDTH=16, sharing clock and reset.
//   Honours FIB_SATURATE_EN for the overflow beat expectation.
// ---------------------------------------------------------------------------
module tb_fibonacci_multi_lane;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_start = 1'b0;
    logic [15:0] a_seed0 = '0;
    logic [15:0] a_seed1 = '0;
    logic [7:0]  a_len   = '0;
    logic        a_busy, a_done, a_ovf;

    logic        b_start = 1'b0;
    logic [15:0] b_seed0 = '0;
    logic [15:0] b_seed1 = '0;
    logic [7:0]  b_len   = '0;
    logic        b_busy, b_done, b_ovf;

    int total = 0;
    int bad   = 0;

    fibonacci_multi_lane_if #(.WIDTH(16), .LANES(2)) a_if ();
    fibonacci_multi_lane_if #(.WIDTH(16), .LANES(1)) b_if ();

    fibonacci_multi_lane #(.WIDTH(16), .LANES(2), .LEN_W(8)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (a_start),
        .seed0    (a_seed0),
        .seed1    (a_seed1),
        .len      (a_len),
        .m_out    (a_if),
        .busy     (a_busy),
        .done     (a_done),
        .overflow (a_ovf)
    );

    fibonacci_multi_lane #(.WIDTH(16), .LANES(1), .LEN_W(8)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (b_start),
        .seed0    (b_seed0),
        .seed1    (b_seed1),
        .len      (b_len),
        .m_out    (b_if),
        .busy     (b_busy),
        .done     (b_done),
        .overflow (b_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] beat2(input logic [15:0] lo, input logic [15:0] hi);
        return {hi, lo};
    endfunction

    task automatic start_a(input logic [15:0] s0, input logic [15:0] s1, input logic [7:0] n);
        a_seed0 = s0;
        a_seed1 = s1;
        a_len   = n;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    logic [15:0] exp_lo [4];
    logic [15:0] exp_hi [4];
    logic [15:0] exp_b  [5];

    initial begin
        exp_lo = '{16'd1, 16'd2, 16'd5, 16'd13};
        exp_hi = '{16'd1, 16'd3, 16'd8, 16'd21};
        exp_b  = '{16'd2, 16'd1, 16'd3, 16'd4, 16'd7};
        a_if.out_ready = 1'b1;
        b_if.out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", a_if.out_valid, 0);
        check("rst_num",   a_if.num, 0);
        check("rst_busy",  a_busy, 0);
        check("rst_done",  a_done, 0);
        check("rst_ovf",   a_ovf, 0);

        // Basic run; start on the last-transfer cycle must be ignored
        start_a(16'd1, 16'd1, 8'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("run_valid%0d", k), a_if.out_valid, 1);
            check($sformatf("run_busy%0d", k), a_busy, 1);
            check($sformatf("run_beat%0d", k), a_if.num, beat2(exp_lo[k], exp_hi[k]));
            if (k == 3) begin
                a_seed0 = 16'd5;
                a_seed1 = 16'd5;
                a_len   = 8'd2;
                a_start = 1'b1;
            end
            tick();
            a_start = 1'b0;
        end
        check("end_done",  a_done, 1);
        check("end_busy",  a_busy, 0);
        check("end_valid", a_if.out_valid, 0);
        check("end_ovf",   a_ovf, 0);
        check("end_hold",  a_if.num, beat2(16'd13, 16'd21));

        // Backpressure on beat 1 (start accepted from DONE)
        start_a(16'd1, 16'd1, 8'd4);
        check("bp_beat0", a_if.num, beat2(16'd1, 16'd1));
        tick();
        a_if.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("bp_hold%0d", c), a_if.num, beat2(16'd2, 16'd3));
            check($sformatf("bp_valid%0d", c), a_if.out_valid, 1);
        end
        a_if.out_ready = 1'b1;
        tick();
        check("bp_beat2", a_if.num, beat2(16'd5, 16'd8));
        tick();
        check("bp_beat3", a_if.num, beat2(16'd13, 16'd21));
        tick();
        check("bp_done", a_done, 1);

        // Long run into overflow, with a start pulse mid-run that must be ignored
        start_a(16'd1, 16'd1, 8'd13);
        for (int k = 0; k < 13; k++) begin
            if (k == 3) begin
                a_seed0 = 16'd7;
                a_seed1 = 16'd7;
                a_len   = 8'd0;
                a_start = 1'b1;
            end
            if (k == 6)  check("long_beat6", a_if.num, beat2(16'd233, 16'd377));
            if (k == 11) begin
                check("long_beat11", a_if.num, beat2(16'd28657, 16'd46368));
                check("long_ovf11", a_ovf, 0);
            end
            if (k == 12) begin
`ifdef FIB_SATURATE_EN
                check("long_beat12", a_if.num, beat2(16'd65535, 16'd65535));
`else
                check("long_beat12", a_if.num, beat2(16'd9489, 16'd55857));
`endif
                check("long_ovf12", a_ovf, 1);
            end
            tick();
            a_start = 1'b0;
        end
        check("long_done", a_done, 1);
        check("long_ovf_sticky", a_ovf, 1);

        // len == 0: done next cycle, never valid, overflow cleared
        start_a(16'd3, 16'd4, 8'd0);
        check("len0_done",  a_done, 1);
        check("len0_valid", a_if.out_valid, 0);
        check("len0_ovf",   a_ovf, 0);
        tick();
        check("len0_valid2", a_if.out_valid, 0);

        // Reset mid-run
        start_a(16'd1, 16'd1, 8'd4);
        tick();
        check("mid_valid_pre", a_if.out_valid, 1);
        rst = 1'b1;
        tick();
        check("mrst_valid", a_if.out_valid, 0);
        check("mrst_num",   a_if.num, 0);
        check("mrst_busy",  a_busy, 0);
        check("mrst_done",  a_done, 0);
        check("mrst_ovf",   a_ovf, 0);
        rst = 1'b0;
        tick();

        // Single-lane instance, seeds 2,1
        b_seed0 = 16'd2;
        b_seed1 = 16'd1;
        b_len   = 8'd5;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("lane1_valid%0d", k), b_if.out_valid, 1);
            check($sformatf("lane1_beat%0d", k), b_if.num, exp_b[k]);
            tick();
        end
        check("lane1_done",  b_done, 1);
        check("lane1_valid", b_if.out_valid, 0);
        check("lane1_ovf",   b_ovf, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
